// File: rtl/mdu_hilo_unit.sv
// ============================================================================
// Module   : mdu_hilo_unit
// Purpose  : Multi-cycle MULT/MULTU/DIV/DIVU unit driving the HI/LO write ports.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module mdu_hilo_unit #(
    parameter int MUL_CYCLES = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [1:0]  op,
    input  logic [31:0] src_a,
    input  logic [31:0] src_b,
    input  logic        flush,
    output logic        busy,
    output logic        hi_w_en,
    output logic        lo_w_en,
    output logic [31:0] hi_w_data,
    output logic [31:0] lo_w_data
);

    localparam logic [3:0] c_MUL_LAST = 4'(MUL_CYCLES);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_DIV  = 2'd2
    } state_t;

    state_t      r_state;
    state_t      w_state_nxt;

    logic [63:0] r_prod;
    logic [3:0]  r_mcnt;
    logic [31:0] r_rem;
    logic [31:0] r_quo;
    logic [31:0] r_dvs;
    logic [4:0]  r_cnt;
    logic        r_fix;
    logic        r_quo_neg;
    logic        r_rem_neg;
    logic        r_dvz;
    logic        r_wen;
    logic [31:0] r_hi;
    logic [31:0] r_lo;

    logic        w_accept;
    logic        w_mul_done;
    logic        w_div_done;
    logic        w_signed;
    logic        w_a_neg;
    logic        w_b_neg;
    logic [32:0] w_ext_a;
    logic [32:0] w_ext_b;
    logic [63:0] w_prod;
    logic [31:0] w_abs_a;
    logic [31:0] w_abs_b;
    logic [32:0] w_trial;
    logic [32:0] w_diff;

    assign w_accept   = (r_state == ST_IDLE) && start && !flush;
    assign w_mul_done = (r_state == ST_MUL) && (r_mcnt == c_MUL_LAST);
    assign w_div_done = (r_state == ST_DIV) && r_fix;

    // op[0] selects the unsigned flavour for both multiply and divide
    assign w_signed = !op[0];
    assign w_a_neg  = w_signed & src_a[31];
    assign w_b_neg  = w_signed & src_b[31];
    assign w_ext_a  = {w_a_neg, src_a};
    assign w_ext_b  = {w_b_neg, src_b};
    assign w_prod   = {{31{w_ext_a[32]}}, w_ext_a} * {{31{w_ext_b[32]}}, w_ext_b};
    assign w_abs_a  = w_a_neg ? (32'd0 - src_a) : src_a;
    assign w_abs_b  = w_b_neg ? (32'd0 - src_b) : src_b;

    assign w_trial  = {r_rem, r_quo[31]};
    assign w_diff   = w_trial - {1'b0, r_dvs};

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: if (w_accept) w_state_nxt = op[1] ? ST_DIV : ST_MUL;
            ST_MUL:  if (w_mul_done || flush) w_state_nxt = ST_IDLE;
            ST_DIV:  if (w_div_done || flush) w_state_nxt = ST_IDLE;
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_prod    <= 64'd0;
            r_mcnt    <= 4'd0;
            r_rem     <= 32'd0;
            r_quo     <= 32'd0;
            r_dvs     <= 32'd0;
            r_cnt     <= 5'd0;
            r_fix     <= 1'b0;
            r_quo_neg <= 1'b0;
            r_rem_neg <= 1'b0;
            r_dvz     <= 1'b0;
            r_wen     <= 1'b0;
            r_hi      <= 32'd0;
            r_lo      <= 32'd0;
        end else begin
            r_wen <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_accept && op[1]) begin
                        r_quo     <= w_abs_a;
                        r_rem     <= 32'd0;
                        r_dvs     <= w_abs_b;
                        r_cnt     <= 5'd0;
                        r_fix     <= 1'b0;
                        r_quo_neg <= w_a_neg ^ w_b_neg;
                        r_rem_neg <= w_a_neg;
                        r_dvz     <= (src_b == 32'd0);
                    end else if (w_accept) begin
                        r_prod <= w_prod;
                        r_mcnt <= 4'd1;
                    end
                end
                ST_MUL: begin
                    if (w_mul_done) begin
                        r_wen <= 1'b1;
                        r_hi  <= r_prod[63:32];
                        r_lo  <= r_prod[31:0];
                    end else begin
                        r_mcnt <= r_mcnt + 4'd1;
                    end
                end
                ST_DIV: begin
                    if (r_fix) begin
                        // a zero divisor leaves the dividend in the remainder,
                        // so only the quotient needs overriding
                        r_wen <= 1'b1;
                        r_fix <= 1'b0;
                        r_hi  <= r_rem_neg ? (32'd0 - r_rem) : r_rem;
                        r_lo  <= r_dvz ? 32'hFFFF_FFFF :
                                 (r_quo_neg ? (32'd0 - r_quo) : r_quo);
                    end else begin
                        if (w_diff[32]) begin
                            r_rem <= w_trial[31:0];
                            r_quo <= {r_quo[30:0], 1'b0};
                        end else begin
                            r_rem <= w_diff[31:0];
                            r_quo <= {r_quo[30:0], 1'b1};
                        end
                        r_cnt <= r_cnt + 5'd1;
                        r_fix <= (r_cnt == 5'd31);
                    end
                end
                default: ;
            endcase
        end
    end

    assign busy      = (r_state != ST_IDLE);
    assign hi_w_en   = r_wen;
    assign lo_w_en   = r_wen;
    assign hi_w_data = r_hi;
    assign lo_w_data = r_lo;

endmodule

`default_nettype wire

// File: tb/tb_mdu_hilo_unit.sv
// ============================================================================
// Module   : tb_mdu_hilo_unit
// Purpose  : Scoreboard bench for mdu_hilo_unit with directed vectors.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mdu_hilo_unit;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [1:0]  op = 2'b00;
    logic [31:0] src_a = 32'd0;
    logic [31:0] src_b = 32'd0;
    logic        flush = 1'b0;
    logic        busy;
    logic        hi_w_en;
    logic        lo_w_en;
    logic [31:0] hi_w_data;
    logic [31:0] lo_w_data;

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
        int          at;
    } exp_t;

    exp_t sb[$];
    int   cyc = 0;
    int   total = 0;
    int   bad = 0;

    mdu_hilo_unit #(.MUL_CYCLES(2)) dut (
        .clk(clk), .reset(reset), .start(start), .op(op),
        .src_a(src_a), .src_b(src_b), .flush(flush), .busy(busy),
        .hi_w_en(hi_w_en), .lo_w_en(lo_w_en),
        .hi_w_data(hi_w_data), .lo_w_data(lo_w_data)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: every write pulse is matched against the oldest expected result
    always @(negedge clk) begin
        if (hi_w_en || lo_w_en) begin
            exp_t e;
            chk("en pair", {hi_w_en, lo_w_en}, 2'b11);
            if (sb.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected pulse: got hi=%h lo=%h, required no pulse", hi_w_data, lo_w_data);
            end else begin
                e = sb.pop_front();
                chk("hi data", hi_w_data, e.hi);
                chk("lo data", lo_w_data, e.lo);
                chk("pulse cycle", cyc, e.at);
            end
        end
    end

    // Called aligned to a negedge; returns at the negedge after acceptance edge E0
    task automatic issue(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] eh, input logic [31:0] el, input int lat);
        start = 1'b1;
        op    = o;
        src_a = a;
        src_b = b;
        sb.push_back('{hi: eh, lo: el, at: cyc + 1 + lat});
        @(negedge clk);
        start = 1'b0;
        op    = 2'($urandom);
        src_a = $urandom;
        src_b = $urandom;
    endtask

    task automatic wait_until(input int t);
        for (int i = 0; i < 200 && cyc < t; i++) @(negedge clk);
    endtask

    task automatic drain();
        for (int i = 0; i < 100 && sb.size() != 0; i++) @(negedge clk);
        total++;
        if (sb.size() != 0) begin
            bad++;
            $display("FAIL drain timeout: got %0d results outstanding, required 0", sb.size());
            sb.delete();
        end
    endtask

    task automatic quiet_window(input string name);
        int en_seen;
        en_seen = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (hi_w_en || lo_w_en) en_seen++;
        end
        chk(name, en_seen, 0);
    endtask

    initial begin
        int e0;
        #1 reset = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset busy", busy, 0);
        chk("reset en", {hi_w_en, lo_w_en}, 0);
        chk("reset hi", hi_w_data, 0);
        chk("reset lo", lo_w_data, 0);
        reset = 1'b1;
        @(negedge clk);

        issue(2'b00, 32'hFFFF_FFFD, 32'd7, 32'hFFFF_FFFF, 32'hFFFF_FFEB, 2);
        chk("mult busy e0", busy, 1);
        @(negedge clk);
        chk("mult busy e0+1", busy, 1);
        @(negedge clk);
        chk("mult busy e0+2", busy, 0);
        drain();

        issue(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 2);
        drain();
        issue(2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0, 32'h1, 2);
        drain();

        issue(2'b10, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 33);
        drain();
        issue(2'b11, 32'd100, 32'd7, 32'd2, 32'd14, 33);
        drain();
        issue(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 32'h8000_0000, 33);
        drain();
        issue(2'b11, 32'd100, 32'd0, 32'd100, 32'hFFFF_FFFF, 33);
        drain();
        issue(2'b10, 32'hFFFF_FF9C, 32'd0, 32'hFFFF_FF9C, 32'hFFFF_FFFF, 33);
        drain();

        // Start while busy is ignored; a start in the pulse cycle is accepted
        issue(2'b11, 32'd100, 32'd7, 32'd2, 32'd14, 33);
        e0 = cyc;
        wait_until(e0 + 4);
        start = 1'b1; op = 2'b11; src_a = 32'd1000; src_b = 32'd3;
        @(negedge clk);
        start = 1'b0;
        wait_until(e0 + 33);
        issue(2'b00, 32'd5, 32'd6, 32'd0, 32'd30, 2);
        drain();

        // Flush mid-divide
        issue(2'b11, 32'd1000, 32'd3, 32'd1, 32'd333, 33);
        e0 = cyc;
        wait_until(e0 + 9);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        chk("flush busy", busy, 0);
        void'(sb.pop_back());
        quiet_window("flush no pulse");

        // Asynchronous reset mid-divide
        issue(2'b10, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 33);
        e0 = cyc;
        wait_until(e0 + 19);
        #2 reset = 1'b0;
        #1;
        chk("areset busy", busy, 0);
        chk("areset en", {hi_w_en, lo_w_en}, 0);
        chk("areset hi", hi_w_data, 0);
        chk("areset lo", lo_w_data, 0);
        void'(sb.pop_back());
        repeat (3) @(negedge clk);
        reset = 1'b1;
        quiet_window("areset no pulse");
        issue(2'b01, 32'd3, 32'd4, 32'd0, 32'd12, 2);
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, required completion");
        $fatal(1, "watchdog");
    end

endmodule

`default_nettype wire
